// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID flush request,
// RUN/HALT control for syscall halt/resume, and saturating performance counters.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_redirect,
  input  logic [31:0]       br_target,
  input  logic              jmp_valid,
  input  logic [31:0]       jmp_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       pc_out,
  output logic [31:0]       ir_out,
  output logic              flush,
  output logic              halted,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  redir_cnt
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  // PC is kept as a word address; bits [1:0] are always zero.
  localparam logic [29:0] RESET_WPC = RESET_PC[31:2];

  state_e           state_q;
  logic [29:0]      pc_q;
  logic [29:0]      pc_d;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] redir_q;
  logic             run;
  logic             stall_inc;
  logic             unused_tgt_lo;

  assign run           = (state_q == S_RUN);
  assign flush         = run & (br_redirect | jmp_valid);
  assign stall_inc     = run & stall & ~br_redirect & ~jmp_valid;
  assign imem_addr     = pc_q[ADDR_W-1:0];
  assign pc_out        = {pc_q, 2'b00} + 32'd4;
  assign ir_out        = run ? imem_rdata : 32'h0;
  assign halted        = ~run;
  assign cyc_cnt       = cyc_q;
  assign stall_cnt     = stall_q;
  assign redir_cnt     = redir_q;
  assign unused_tgt_lo = ^{br_target[1:0], jmp_target[1:0]};

  // Next PC: branch beats jump beats stall/halt-hold beats sequential.
  always_comb begin
    pc_d = pc_q;
    if (run) begin
      if (br_redirect) begin
        pc_d = br_target[31:2];
      end else if (jmp_valid) begin
        pc_d = jmp_target[31:2];
      end else if (!stall && !halt_req) begin
        pc_d = pc_q + 30'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_WPC;
      cyc_q   <= '0;
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_RUN: begin
          if (halt_req) state_q <= S_HALT;
        end
        S_HALT: begin
          if (resume && !halt_req) state_q <= S_RUN;
        end
        default: state_q <= S_RUN;
      endcase
      // Counters saturate at all-ones instead of wrapping.
      if (run && (cyc_q != '1))         cyc_q   <= cyc_q + CNT_W'(1);
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush && (redir_q != '1))     redir_q <= redir_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized run against a
// behavioural model; a second instance with 4-bit counters exercises saturation.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, br = 1'b0, jv = 1'b0, hr = 1'b0, res = 1'b0;
  logic [31:0] bt = 32'h0, jt = 32'h0;

  logic [9:0]  addr_a, addr_b;
  logic [31:0] rdata_a, rdata_b, pc_a, pc_b, ir_a, ir_b;
  logic        flush_a, flush_b, halted_a, halted_b;
  logic [31:0] cyc_a, st_a, rd_a;
  logic [3:0]  cyc_b, st_b, rd_b;

  int checks = 0;
  int failures = 0;

  // Model state: byte PC, halt flag, unbounded event counts.
  logic [31:0] m_pc;
  bit          m_halt;
  longint      m_cyc, m_st, m_rd;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [9:0] a);
    return 32'hA500_0000 ^ (32'(a) * 32'h0001_9E37);
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  assign rdata_a = rom(addr_a);
  assign rdata_b = rom(addr_b);

  fetch_pc_unit #(.RESET_PC(32'h0), .ADDR_W(10), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .br_redirect(br), .br_target(bt),
    .jmp_valid(jv), .jmp_target(jt), .halt_req(hr), .resume(res),
    .imem_addr(addr_a), .imem_rdata(rdata_a), .pc_out(pc_a), .ir_out(ir_a),
    .flush(flush_a), .halted(halted_a), .cyc_cnt(cyc_a), .stall_cnt(st_a),
    .redir_cnt(rd_a));

  fetch_pc_unit #(.RESET_PC(32'h0), .ADDR_W(10), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .stall(stall), .br_redirect(br), .br_target(bt),
    .jmp_valid(jv), .jmp_target(jt), .halt_req(hr), .resume(res),
    .imem_addr(addr_b), .imem_rdata(rdata_b), .pc_out(pc_b), .ir_out(ir_b),
    .flush(flush_b), .halted(halted_b), .cyc_cnt(cyc_b), .stall_cnt(st_b),
    .redir_cnt(rd_b));

  task automatic clear_inputs();
    stall = 1'b0; br = 1'b0; jv = 1'b0; hr = 1'b0; res = 1'b0;
    bt = 32'h0; jt = 32'h0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_halt = 1'b0; m_cyc = 0; m_st = 0; m_rd = 0;
  endtask

  // Advance one clock with the current inputs, updating the model from the rules.
  task automatic tick();
    logic [31:0] npc;
    bit          nh;
    npc = m_pc;
    nh  = m_halt;
    if (m_halt) begin
      if (res && !hr) nh = 1'b0;
    end else begin
      if (br)                npc = bt & ~32'd3;
      else if (jv)           npc = jt & ~32'd3;
      else if (!(stall || hr)) npc = m_pc + 32'd4;
      nh = hr;
      m_cyc++;
      if (stall && !br && !jv) m_st++;
      if (br || jv) m_rd++;
    end
    @(posedge clk);
    #1;
    m_pc   = npc;
    m_halt = nh;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    checks++; if (pc_a !== 32'h4) begin failures++; $display("FAIL reset_pc_out got=%h exp=%h", pc_a, 32'h4); end
    checks++; if (addr_a !== 10'h0) begin failures++; $display("FAIL reset_imem_addr got=%h exp=0", addr_a); end
    checks++; if (flush_a !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush_a); end
    checks++; if (halted_a !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted_a); end
    checks++; if ({cyc_a, st_a, rd_a} !== 96'h0) begin failures++; $display("FAIL reset_counters got=%h/%h/%h exp=0", cyc_a, st_a, rd_a); end
    checks++; if (ir_a !== rom(10'h0)) begin failures++; $display("FAIL reset_ir got=%h exp=%h", ir_a, rom(10'h0)); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      checks++; if (addr_a !== 10'(i)) begin failures++; $display("FAIL seq_addr step=%0d got=%h exp=%h", i, addr_a, i); end
      tick();
    end
    checks++; if (addr_a !== 10'h4 || pc_a !== 32'h14) begin failures++; $display("FAIL seq_final got=%h/%h exp=004/00000014", addr_a, pc_a); end
    checks++; if (cyc_a !== 32'd4) begin failures++; $display("FAIL seq_cyc_cnt got=%0d exp=4", cyc_a); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (addr_a !== 10'h2 || flush_a !== 1'b0) begin failures++; $display("FAIL stall_hold step=%0d got addr=%h flush=%b exp addr=002 flush=0", i, addr_a, flush_a); end
      tick();
    end
    stall = 1'b0;
    checks++; if (addr_a !== 10'h2) begin failures++; $display("FAIL stall_after got=%h exp=002", addr_a); end
    tick();
    checks++; if (addr_a !== 10'h3) begin failures++; $display("FAIL stall_resume got=%h exp=003", addr_a); end
    checks++; if (st_a !== 32'd2) begin failures++; $display("FAIL stall_cnt got=%0d exp=2", st_a); end
  endtask

  task automatic test_branch_over_stall();
    longint rd0, st0;
    rd0 = m_rd; st0 = m_st;
    stall = 1'b1; br = 1'b1; bt = 32'h43;
    #1;
    checks++; if (flush_a !== 1'b1) begin failures++; $display("FAIL br_stall_flush got=%b exp=1", flush_a); end
    tick();
    clear_inputs();
    checks++; if (pc_out_chk(pc_a) !== 32'h40) begin failures++; $display("FAIL br_stall_pc got=%h exp=00000040", pc_a - 32'd4); end
    checks++; if (rd_a !== 32'(rd0 + 1)) begin failures++; $display("FAIL br_stall_redir got=%0d exp=%0d", rd_a, rd0 + 1); end
    checks++; if (st_a !== 32'(st0)) begin failures++; $display("FAIL br_stall_stallcnt got=%0d exp=%0d", st_a, st0); end
  endtask

  function automatic logic [31:0] pc_out_chk(input logic [31:0] p);
    return p - 32'd4;
  endfunction

  task automatic test_priority();
    jv = 1'b1; jt = 32'h100; br = 1'b1; bt = 32'h200;
    tick();
    clear_inputs();
    checks++; if (pc_a !== 32'h204) begin failures++; $display("FAIL prio_pc got=%h exp=00000204", pc_a); end
    jv = 1'b1; jt = 32'h102;
    tick();
    clear_inputs();
    checks++; if (pc_a !== 32'h104) begin failures++; $display("FAIL jmp_pc got=%h exp=00000104", pc_a); end
  endtask

  task automatic test_halt();
    logic [31:0] cyc0;
    jv = 1'b1; jt = 32'h20;
    tick();
    clear_inputs();
    hr = 1'b1;
    tick();
    hr = 1'b0;
    checks++; if (halted_a !== 1'b1) begin failures++; $display("FAIL halt_enter got=%b exp=1", halted_a); end
    cyc0 = cyc_a;
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom); br = 1'($urandom); jv = 1'($urandom); hr = 1'($urandom);
      bt = $urandom; jt = $urandom;
      #1;
      checks++; if (ir_a !== 32'h0 || flush_a !== 1'b0 || addr_a !== 10'h8) begin
        failures++; $display("FAIL halt_hold step=%0d got ir=%h flush=%b addr=%h exp ir=0 flush=0 addr=008", i, ir_a, flush_a, addr_a);
      end
      tick();
    end
    clear_inputs();
    checks++; if (cyc_a !== cyc0) begin failures++; $display("FAIL halt_cyc_frozen got=%0d exp=%0d", cyc_a, cyc0); end
    hr = 1'b1; res = 1'b1;
    tick();
    checks++; if (halted_a !== 1'b1) begin failures++; $display("FAIL halt_resume_and_req got=%b exp=1", halted_a); end
    hr = 1'b0;
    tick();
    res = 1'b0;
    checks++; if (halted_a !== 1'b0 || addr_a !== 10'h8 || ir_a !== rom(10'h8)) begin
      failures++; $display("FAIL resume_state got halted=%b addr=%h ir=%h exp halted=0 addr=008 ir=%h", halted_a, addr_a, ir_a, rom(10'h8));
    end
    tick();
    checks++; if (pc_a !== 32'h28) begin failures++; $display("FAIL resume_next got=%h exp=00000028", pc_a); end
    res = 1'b1;
    tick();
    res = 1'b0;
    checks++; if (halted_a !== 1'b0 || pc_a !== 32'h2C) begin failures++; $display("FAIL resume_in_run got halted=%b pc_out=%h exp 0/0000002c", halted_a, pc_a); end
  endtask

  task automatic test_random();
    logic [31:0] exp_ir;
    for (int i = 0; i < 400; i++) begin
      br = ($urandom_range(7) == 0); jv = ($urandom_range(7) == 0);
      stall = ($urandom_range(3) == 0); hr = ($urandom_range(15) == 0);
      res = ($urandom_range(3) == 0);
      bt = $urandom & 32'hFFF; jt = $urandom & 32'hFFF;
      #1;
      exp_ir = m_halt ? 32'h0 : rom(m_pc[11:2]);
      checks++; if (addr_a !== m_pc[11:2] || pc_a !== m_pc + 32'd4 || ir_a !== exp_ir) begin
        failures++; $display("FAIL rnd_fetch cyc=%0d got addr=%h pc_out=%h ir=%h exp addr=%h pc_out=%h ir=%h", i, addr_a, pc_a, ir_a, m_pc[11:2], m_pc + 32'd4, exp_ir);
      end
      checks++; if (flush_a !== (!m_halt && (br || jv)) || halted_a !== m_halt) begin
        failures++; $display("FAIL rnd_ctrl cyc=%0d got flush=%b halted=%b exp flush=%b halted=%b", i, flush_a, halted_a, !m_halt && (br || jv), m_halt);
      end
      checks++; if (64'(cyc_a) !== sat(m_cyc, 32) || 64'(st_a) !== sat(m_st, 32) || 64'(rd_a) !== sat(m_rd, 32)) begin
        failures++; $display("FAIL rnd_cnt32 cyc=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", i, cyc_a, st_a, rd_a, m_cyc, m_st, m_rd);
      end
      checks++; if (64'(cyc_b) !== sat(m_cyc, 4) || 64'(st_b) !== sat(m_st, 4) || 64'(rd_b) !== sat(m_rd, 4) || pc_b !== pc_a) begin
        failures++; $display("FAIL rnd_cnt4 cyc=%0d got %0d/%0d/%0d pc_out=%h exp %0d/%0d/%0d pc_out=%h", i, cyc_b, st_b, rd_b, pc_b, sat(m_cyc, 4), sat(m_st, 4), sat(m_rd, 4), m_pc + 32'd4);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    res = 1'b1;
    tick();
    res = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (cyc_b !== 4'hF) begin failures++; $display("FAIL sat_cyc got=%h exp=f", cyc_b); end
    checks++; if (cyc_a !== 32'(m_cyc)) begin failures++; $display("FAIL wide_cyc got=%0d exp=%0d", cyc_a, m_cyc); end
  endtask

  task automatic test_reset_in_halt();
    jv = 1'b1; jt = 32'h80;
    tick();
    clear_inputs();
    hr = 1'b1;
    tick();
    hr = 1'b0;
    tick();
    checks++; if (halted_a !== 1'b1) begin failures++; $display("FAIL rsth_pre got=%b exp=1", halted_a); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (halted_a !== 1'b0 || pc_a !== 32'h4 || cyc_a !== 32'h0 || halted_b !== 1'b0) begin
      failures++; $display("FAIL rsth_async got halted=%b pc_out=%h cyc=%0d exp 0/00000004/0", halted_a, pc_a, cyc_a);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick();
    checks++; if (pc_a !== 32'h8 || cyc_a !== 32'd1) begin failures++; $display("FAIL rsth_run got pc_out=%h cyc=%0d exp 00000008/1", pc_a, cyc_a); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_branch_over_stall();
    test_priority();
    test_halt();
    test_random();
    test_saturation();
    test_reset_in_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
